light_decoder: RTL



---
 rtl/light_decoder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/light_decoder.sv
// light_decoder
// -------------
// Receive-side decoder for the 24-bit RGB light bus. It recovers the 3-bit
// colour code {R,G,B} that the lights selector put on the bus. It filters
// short glitches, reports each newly settled colour, and flags white. It also
// flags byte patterns that the colour converter cannot produce, and checks
// that colour steps follow the button sequence 1->2->3->4->5->6->1.
//
// Parameters
//   STABLE_CYCLES  consecutive identical samples needed to accept (1..15)
//   ERR_W          width of the saturating error counter
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   light         RGB bus, [23:16]=R, [15:8]=G, [7:0]=B
//   colour        last accepted colour code {R,G,B}
//   colour_valid  one-cycle pulse when colour takes a new accepted value
//   is_white      high while the accepted colour is 3'b111
//   code_err      one-cycle pulse when an unproducible pattern settles
//   seq_err       one-cycle pulse when a colour step breaks the sequence
//   err_count     saturating count of code_err and seq_err events
module light_decoder #(
  parameter int STABLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      light,
  output logic [2:0]       colour,
  output logic             colour_valid,
  output logic             is_white,
  output logic             code_err,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0]       STABLE_N  = 4'(STABLE_CYCLES);
  localparam logic [3:0]       STABLE_M1 = 4'(STABLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  logic [23:0]      light_q;
  logic [2:0]       cand_code;
  logic             cand_inv;
  logic [3:0]       cnt;
  logic             have_acc;
  logic [2:0]       prev;
  logic             have_prev;

  logic [2:0]       cls_code;
  logic             cls_inv;
  logic             cls_new;
  logic             reaches;
  logic             accept;
  logic             coloured;
  logic [2:0]       next_prev;
  logic [ERR_W-1:0] err_inc;

  // Returns {invalid, bit} for one colour byte: 00 is a 0, FF is a 1,
  // and anything else cannot come from the converter.
  function automatic logic [1:0] byte_class(input logic [7:0] b);
    if (b == 8'h00)      return 2'b00;
    else if (b == 8'hFF) return 2'b01;
    else                 return 2'b10;
  endfunction

  // Classify the registered sample. Then decide whether this edge is the one
  // where the filter count reaches the threshold, and whether that settled
  // class is actually news compared with what has already been accepted.
  always_comb begin
    logic [1:0] r_cls;
    logic [1:0] g_cls;
    logic [1:0] b_cls;
    r_cls    = byte_class(light_q[23:16]);
    g_cls    = byte_class(light_q[15:8]);
    b_cls    = byte_class(light_q[7:0]);
    cls_code = {r_cls[0], g_cls[0], b_cls[0]};
    cls_inv  = r_cls[1] | g_cls[1] | b_cls[1];

    // While the candidate is invalid its code bits are meaningless, so an
    // invalid sample never restarts an invalid candidate.
    cls_new  = (cls_inv != cand_inv) || (!cls_inv && (cls_code != cand_code));

    // A restart counts as the first sample, so a threshold of 1 accepts on
    // the load edge itself.
    reaches  = cls_new ? (STABLE_CYCLES == 1) : (cnt == STABLE_M1);

    // An invalid class is always news. A valid class is news only when it
    // differs from the accepted colour, or when nothing has been accepted yet.
    accept   = reaches && (cls_inv || !have_acc || (cls_code != colour));

    coloured  = (cls_code != 3'd0) && (cls_code != 3'd7);
    next_prev = (prev == 3'd6) ? 3'd1 : prev + 3'd1;
    err_inc   = (err_count == ERR_MAX) ? err_count : err_count + ERR_W'(1);
  end

  // Input register, glitch filter, accept handling and sequence tracking.
  // All outputs are registered here, so no combinational path reaches them
  // from light.
  always_ff @(posedge clk) begin
    if (rst) begin
      light_q      <= 24'h000000;
      cand_code    <= 3'd0;
      cand_inv     <= 1'b1;
      cnt          <= 4'd0;
      colour       <= 3'd0;
      colour_valid <= 1'b0;
      is_white     <= 1'b0;
      code_err     <= 1'b0;
      seq_err      <= 1'b0;
      err_count    <= '0;
      have_acc     <= 1'b0;
      prev         <= 3'd0;
      have_prev    <= 1'b0;
    end else begin
      light_q      <= light;
      colour_valid <= 1'b0;
      code_err     <= 1'b0;
      seq_err      <= 1'b0;

      if (cls_new) begin
        cand_code <= cls_code;
        cand_inv  <= cls_inv;
        cnt       <= 4'd1;
      end else if (cnt < STABLE_N) begin
        cnt <= cnt + 4'd1;
      end

      if (accept) begin
        if (cls_inv) begin
          // Bad pattern: report it once, but leave the colour and the
          // sequence history alone.
          code_err  <= 1'b1;
          err_count <= err_inc;
        end else begin
          colour       <= cls_code;
          colour_valid <= 1'b1;
          have_acc     <= 1'b1;
          is_white     <= (cls_code == 3'd7);
          // Black and white break the chain, so the next coloured value
          // starts a fresh sequence and is not checked.
          if (coloured) begin
            if (have_prev && (cls_code != next_prev)) begin
              seq_err   <= 1'b1;
              err_count <= err_inc;
            end
            prev      <= cls_code;
            have_prev <= 1'b1;
          end else begin
            have_prev <= 1'b0;
          end
        end
      end
    end
  end

endmodule
